univ_shift_reg: RTL and testbench

Parametrised universal shift register: the multi-bit successor of the team's single-bit D flip-flop with asynchronous reset.
- Holds a WIDTH-bit state.
- Each enabled clock, performs one of: hold, logical shift left/right, rotate left/right, arithmetic shift right, or parallel load.
- Used as a serialiser/deserialiser, a rotating mask generator and a general load-able pipeline register in datapath blocks.

---
 rtl/shift_pkg.sv | 17 +
 rtl/univ_shift_next.sv | 37 +++
 rtl/univ_shift_reg.sv | 57 +++++
 tb/tb_univ_shift_reg.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the universal shift register.
package shift_pkg;

    localparam int SHIFT_MODE_W = 3;

    typedef enum logic [SHIFT_MODE_W-1:0] {
        HOLD = 3'b000,
        SHL  = 3'b001,
        SHR  = 3'b010,
        ROL  = 3'b011,
        ROR  = 3'b100,
        ASR  = 3'b101,
        LOAD = 3'b110,
        RSVD = 3'b111
    } shift_mode_e;

endpackage

// File: rtl/univ_shift_next.sv
// Next-state logic for the universal shift register: purely combinational.
// err flags the reserved mode so the register stage can pulse mode_err.
module univ_shift_next
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]        q,
    input  logic [SHIFT_MODE_W-1:0] mode,
    input  logic                    sin_l,
    input  logic                    sin_r,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        nxt,
    output logic                    err
);

    // Select the next register value for the requested operation.
    always_comb begin
        nxt = q;
        err = 1'b0;
        case (shift_mode_e'(mode))
            HOLD:    nxt = q;
            SHL:     nxt = {q[WIDTH-2:0], sin_r};
            SHR:     nxt = {sin_l, q[WIDTH-1:1]};
            ROL:     nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            ROR:     nxt = {q[0], q[WIDTH-1:1]};
            ASR:     nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            LOAD:    nxt = din;
            RSVD: begin
                nxt = q;
                err = 1'b1;
            end
            default: nxt = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, arithmetic shift, or load
// on each enabled edge. Async reset beats sync clear, which beats enable.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [SHIFT_MODE_W-1:0] mode,
    input  logic                    sin_l,
    input  logic                    sin_r,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        q,
    output logic                    sout_l,
    output logic                    sout_r,
    output logic                    mode_err
);

    logic [WIDTH-1:0] nxt;
    logic             err;

    univ_shift_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q     (q),
        .mode  (mode),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .din   (din),
        .nxt   (nxt),
        .err   (err)
    );

    // State register with clr/en priority; mode_err is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= RST_VAL;
            mode_err <= 1'b0;
        end else if (clr) begin
            q        <= RST_VAL;
            mode_err <= 1'b0;
        end else if (en) begin
            q        <= nxt;
            mode_err <= err;
        end else begin
            mode_err <= 1'b0;
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, RST_VAL=8'hA5).
module tb_univ_shift_reg;
    import shift_pkg::*;

    localparam int         WIDTH   = 8;
    localparam logic [7:0] RST_VAL = 8'hA5;

    logic                    clk;
    logic                    rst;
    logic                    clr;
    logic                    en;
    logic [SHIFT_MODE_W-1:0] mode;
    logic                    sin_l;
    logic                    sin_r;
    logic [WIDTH-1:0]        din;
    logic [WIDTH-1:0]        q;
    logic                    sout_l;
    logic                    sout_r;
    logic                    mode_err;

    int n_checks = 0;
    int n_fail   = 0;

    univ_shift_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .en       (en),
        .mode     (mode),
        .sin_l    (sin_l),
        .sin_r    (sin_r),
        .din      (din),
        .q        (q),
        .sout_l   (sout_l),
        .sout_r   (sout_r),
        .mode_err (mode_err)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input shift_mode_e m, input logic [7:0] d);
        en   = 1'b1;
        mode = m;
        din  = d;
        step();
    endtask

    initial begin
        logic [7:0] rol_exp [8];
        logic [7:0] ror_exp [8];
        rol_exp = '{8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96};
        ror_exp = '{8'h4B, 8'hA5, 8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96};

        rst = 1'b0; clr = 1'b0; en = 1'b0; mode = HOLD;
        sin_l = 1'b0; sin_r = 1'b0; din = 8'h00;

        // 1. async reset between edges, then clk edges under reset
        #2 rst = 1'b1;
        #1;
        check("rst_q", 32'(q), 32'(RST_VAL));
        check("rst_err", 32'(mode_err), 32'h0);
        check("rst_sout_l", 32'(sout_l), 32'h1);
        check("rst_sout_r", 32'(sout_r), 32'h1);
        en = 1'b1; mode = LOAD; din = 8'h3C;
        step();
        step();
        check("rst_hold_q", 32'(q), 32'hA5);
        rst = 1'b0; en = 1'b0;
        #2;

        // 2. load, shift left, shift right
        op(LOAD, 8'h81);
        check("load_81", 32'(q), 32'h81);
        sin_r = 1'b1;
        op(SHL, 8'h00);
        check("shl_q", 32'(q), 32'h03);
        check("shl_sout_l", 32'(sout_l), 32'h0);
        check("shl_sout_r", 32'(sout_r), 32'h1);
        sin_r = 1'b0; sin_l = 1'b1;
        op(SHR, 8'h00);
        check("shr_q", 32'(q), 32'h81);
        sin_l = 1'b0;
        op(SHL, 8'h00);
        check("shl_sin0", 32'(q), 32'h02);
        op(SHR, 8'h00);
        check("shr_sin0", 32'(q), 32'h01);
        op(HOLD, 8'hEE);
        check("hold_en", 32'(q), 32'h01);

        // 3. rotates are lossless over WIDTH steps
        op(LOAD, 8'h96);
        for (int i = 0; i < 8; i++) begin
            op(ROL, 8'h00);
            check($sformatf("rol_%0d", i), 32'(q), 32'(rol_exp[i]));
        end
        for (int i = 0; i < 8; i++) begin
            op(ROR, 8'h00);
            check($sformatf("ror_%0d", i), 32'(q), 32'(ror_exp[i]));
        end

        // 4. arithmetic shift right replicates the sign bit
        op(LOAD, 8'h90);
        sin_l = 1'b0;
        op(ASR, 8'h00);
        check("asr_1", 32'(q), 32'hC8);
        op(ASR, 8'h00);
        check("asr_2", 32'(q), 32'hE4);
        op(LOAD, 8'h42);
        sin_l = 1'b1;
        op(ASR, 8'h00);
        check("asr_pos", 32'(q), 32'h21);
        sin_l = 1'b0;

        // 5. reserved mode
        op(LOAD, 8'h12);
        op(RSVD, 8'hFF);
        check("rsvd_q", 32'(q), 32'h12);
        check("rsvd_err", 32'(mode_err), 32'h1);
        op(HOLD, 8'h00);
        check("rsvd_err_drop", 32'(mode_err), 32'h0);
        op(RSVD, 8'h00);
        op(RSVD, 8'h00);
        check("rsvd_b2b_err", 32'(mode_err), 32'h1);
        en = 1'b0;
        step();
        check("rsvd_en0_drop", 32'(mode_err), 32'h0);
        mode = RSVD;
        step();
        check("rsvd_en0_err", 32'(mode_err), 32'h0);
        check("rsvd_en0_q", 32'(q), 32'h12);

        // 6. clr beats en; en=0 holds
        op(RSVD, 8'h00);
        clr = 1'b1; en = 1'b1; mode = LOAD; din = 8'hFF;
        step();
        check("clr_q", 32'(q), 32'hA5);
        check("clr_err", 32'(mode_err), 32'h0);
        clr = 1'b0; en = 1'b0;
        step();
        check("en0_hold", 32'(q), 32'hA5);

        // async reset mid-operation
        op(LOAD, 8'h3C);
        check("load_3c", 32'(q), 32'h3C);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_q", 32'(q), 32'hA5);
        #3 rst = 1'b0;
        op(SHL, 8'h00);
        check("post_rst_shl", 32'(q), 32'h4A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
